// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, default sizes and the one-hot helper for the memory-port arbiter
// and any other arbiter that reuses the round-robin picker.
package mem_port_arbiter_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ADDR_SIZE = 4;
    localparam int DEF_BYTE_SIZE = 8;

    // Widest requester count any instance may use; onehot() is sized to it.
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef logic [DEF_ADDR_SIZE-1:0]       addr_t;
    typedef logic [DEF_BYTE_SIZE-1:0]       data_t;
    typedef logic [DEF_NUM_REQ-1:0]         req_vec_t;
    typedef logic [$clog2(DEF_NUM_REQ)-1:0] idx_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request found scanning upward
// from ptr and wrapping at NUM_REQ-1, returned both one-hot and as an index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int j;

    // The wrap is explicit so non-power-of-two counts never index past NUM_REQ-1.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = IDX_W'(j);
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory write port and one combinational read
// port among NUM_REQ requesters, with a lock for multi-cycle bursts.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int BYTE_SIZE = DEF_BYTE_SIZE
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             we,
    input  logic [NUM_REQ-1:0]             lock,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   addr,
    input  logic [NUM_REQ*BYTE_SIZE-1:0]   wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [BYTE_SIZE-1:0]           rdata,
    output logic                           mem_wen,
    output logic [ADDR_SIZE-1:0]           mem_waddr,
    output logic [BYTE_SIZE-1:0]           mem_wdata,
    output logic [ADDR_SIZE-1:0]           mem_raddr,
    input  logic [BYTE_SIZE-1:0]           mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic               owner_valid;
    logic               owner_hit;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic [MAX_REQ-1:0] owner_oh_full;
    logic [NUM_REQ-1:0] owner_oh;
    logic               unused_oh;

    logic [NUM_REQ-1:0] sel_oh;
    logic [IDX_W-1:0]   g_idx;
    logic               g_any;
    logic [IDX_W-1:0]   ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_oh_full = onehot(MAX_IDX_W'(owner));
    assign owner_oh      = owner_oh_full[NUM_REQ-1:0];
    assign unused_oh     = ^owner_oh_full;

    // A locked owner keeps the port only while it is still requesting.
    assign owner_hit = owner_valid & req[owner];
    assign sel_oh    = owner_hit ? owner_oh : pick_gnt;
    assign g_idx     = owner_hit ? owner : pick_idx;
    assign g_any     = owner_hit | pick_any;

    assign gnt     = reset_n ? sel_oh : '0;
    assign mem_wen = reset_n & g_any & we[g_idx];

    always_comb begin
        mem_waddr = addr[0 +: ADDR_SIZE];
        mem_wdata = wdata[0 +: BYTE_SIZE];
        if (g_any) begin
            mem_waddr = addr[int'(g_idx)*ADDR_SIZE +: ADDR_SIZE];
            mem_wdata = wdata[int'(g_idx)*BYTE_SIZE +: BYTE_SIZE];
        end
    end

    assign mem_raddr = mem_waddr;
    assign ptr_next  = (g_idx == IDX_W'(NUM_REQ-1)) ? '0 : g_idx + 1'b1;

    // Accepted reads capture the memory output; a locked accept freezes the pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr         <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            rdata       <= '0;
            rvalid      <= '0;
        end else begin
            rvalid <= '0;
            if (g_any) begin
                if (!we[g_idx]) begin
                    rdata  <= mem_rdata;
                    rvalid <= sel_oh;
                end
                if (lock[g_idx]) begin
                    owner       <= g_idx;
                    owner_valid <= 1'b1;
                end else begin
                    owner_valid <= 1'b0;
                    ptr         <= ptr_next;
                end
            end else begin
                owner_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [3:0]  req, we, lock;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt, rvalid;
    logic [7:0]  rdata;
    logic        mem_wen;
    logic [3:0]  mem_waddr, mem_raddr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [15:0] stage_addr;
    logic [31:0] stage_wdata;

    logic [2:0]  req3, we3, lock3;
    logic [11:0] addr3;
    logic [23:0] wdata3;
    logic [2:0]  gnt3, rvalid3;
    logic [7:0]  rdata3;
    logic        mem_wen3;
    logic [3:0]  mem_waddr3, mem_raddr3;
    logic [7:0]  mem_wdata3, mem_rdata3;

    logic [7:0]  mem [16];

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.NUM_REQ(4), .ADDR_SIZE(4), .BYTE_SIZE(8)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .lock(lock),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.NUM_REQ(3), .ADDR_SIZE(4), .BYTE_SIZE(8)) dut3 (
        .clock(clock), .reset_n(reset_n), .req(req3), .we(we3), .lock(lock3),
        .addr(addr3), .wdata(wdata3), .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3),
        .mem_wen(mem_wen3), .mem_waddr(mem_waddr3), .mem_wdata(mem_wdata3),
        .mem_raddr(mem_raddr3), .mem_rdata(mem_rdata3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory: synchronous write, combinational read; preloaded with a*17 (addr 0 holds 0).
    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 8'(a * 17);
    end
    always @(posedge clock) begin
        if (mem_wen) mem[mem_waddr] <= mem_wdata;
    end
    assign mem_rdata  = mem[mem_raddr];
    assign mem_rdata3 = {4'h0, mem_raddr3};

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic set_field(input int i, input addr_t a, input data_t d);
        stage_addr[i*4 +: 4]  = a;
        stage_wdata[i*8 +: 8] = d;
    endtask

    task automatic apply_stimulus(input logic [3:0] r, input logic [3:0] w, input logic [3:0] l);
        @(posedge clock);
        #1;
        req   = r;
        we    = w;
        lock  = l;
        addr  = stage_addr;
        wdata = stage_wdata;
        @(negedge clock);
    endtask

    // Transaction-level reference: who wins, what the memory holds, what comes back next cycle.
    function automatic int model_pick(input logic [3:0] r, input int p, input bit ov, input int ow);
        if (ov && r[ow]) return ow;
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    initial begin : compare
        int         m_ptr;
        int         m_owner;
        bit         m_owner_v;
        logic [3:0] e_rvalid;
        logic [7:0] e_rdata;
        logic [7:0] model_mem [16];
        int         g;
        int         a;
        logic [3:0] e_gnt;

        m_ptr = 0; m_owner = 0; m_owner_v = 0; e_rvalid = 0; e_rdata = 0;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'(i * 17);
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                m_ptr = 0; m_owner_v = 0; e_rvalid = 0; e_rdata = 0;
                check_output("model_reset_gnt", 32'(gnt), 0);
                check_output("model_reset_wen", 32'(mem_wen), 0);
                check_output("model_reset_rvalid", 32'(rvalid), 0);
                check_output("model_reset_rdata", 32'(rdata), 0);
            end else begin
                g     = model_pick(req, m_ptr, m_owner_v, m_owner);
                e_gnt = (g < 0) ? 4'b0 : 4'(1 << g);
                check_output("model_gnt", 32'(gnt), 32'(e_gnt));
                check_output("model_rvalid", 32'(rvalid), 32'(e_rvalid));
                check_output("model_rdata", 32'(rdata), 32'(e_rdata));
                check_output("model_wen", 32'(mem_wen), (g >= 0) ? 32'(we[g]) : 0);
                if (g >= 0) begin
                    a = int'(addr[g*4 +: 4]);
                    check_output("model_waddr", 32'(mem_waddr), 32'(a));
                    check_output("model_raddr", 32'(mem_raddr), 32'(a));
                    check_output("model_wdata", 32'(mem_wdata), 32'(wdata[g*8 +: 8]));
                    if (we[g]) begin
                        model_mem[a] = wdata[g*8 +: 8];
                        e_rvalid     = 4'b0;
                    end else begin
                        e_rdata  = model_mem[a];
                        e_rvalid = 4'(1 << g);
                    end
                    if (lock[g]) begin
                        m_owner   = g;
                        m_owner_v = 1;
                    end else begin
                        m_owner_v = 0;
                        m_ptr     = (g + 1) % 4;
                    end
                end else begin
                    e_rvalid  = 4'b0;
                    m_owner_v = 0;
                end
            end
        end
    end

    initial begin : stimulus
        logic [3:0] rr_exp [8];
        logic [2:0] g3_exp [4];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        g3_exp = '{3'b001, 3'b100, 3'b001, 3'b100};

        reset_n = 1'b1;
        req = 0; we = 0; lock = 0; addr = 0; wdata = 0;
        stage_addr = 0; stage_wdata = 0;
        req3 = 0; we3 = 0; lock3 = 0; addr3 = 0; wdata3 = 0;
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) set_field(i, addr_t'(i), 8'h00);
        addr = stage_addr;
        req  = 4'b1111;

        @(negedge clock);
        check_output("reset_gnt", 32'(gnt), 0);
        check_output("reset_wen", 32'(mem_wen), 0);
        check_output("reset_rdata", 32'(rdata), 0);
        check_output("reset_rvalid", 32'(rvalid), 0);
        check_output("reset_gnt3", 32'(gnt3), 0);

        $display("[TB] round-robin over all four readers");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check_output("first_gnt", 32'(gnt), 32'(rr_exp[0]));
        for (int k = 1; k < 8; k++) begin
            apply_stimulus(4'b1111, 4'b0000, 4'b0000);
            check_output("rr_gnt", 32'(gnt), 32'(rr_exp[k]));
            check_output("rr_rvalid", 32'(rvalid), 32'(rr_exp[k-1]));
        end
        apply_stimulus(4'b0000, 4'b0000, 4'b0000);
        check_output("rr_last_rvalid", 32'(rvalid), 32'h8);
        check_output("rr_last_rdata", 32'(rdata), 32'h33);

        $display("[TB] write then read of address 3");
        set_field(1, 4'd3, 8'hA5);
        apply_stimulus(4'b0010, 4'b0010, 4'b0000);
        check_output("wr_gnt", 32'(gnt), 32'h2);
        check_output("wr_wen", 32'(mem_wen), 1);
        check_output("wr_waddr", 32'(mem_waddr), 3);
        check_output("wr_wdata", 32'(mem_wdata), 32'hA5);
        set_field(2, 4'd3, 8'h00);
        apply_stimulus(4'b0100, 4'b0000, 4'b0000);
        check_output("rd_gnt", 32'(gnt), 32'h4);
        check_output("rd_rvalid_early", 32'(rvalid), 0);
        apply_stimulus(4'b0000, 4'b0000, 4'b0000);
        check_output("raw_rvalid", 32'(rvalid), 32'h4);
        check_output("raw_rdata", 32'(rdata), 32'hA5);

        $display("[TB] locked burst by requester 2");
        set_field(0, 4'd6, 8'h00);
        set_field(1, 4'd7, 8'h00);
        set_field(2, 4'd5, 8'h00);
        set_field(3, 4'd8, 8'h00);
        apply_stimulus(4'b0100, 4'b0000, 4'b0100);
        check_output("lock_gnt1", 32'(gnt), 32'h4);
        set_field(2, 4'd9, 8'h00);
        apply_stimulus(4'b1111, 4'b0000, 4'b0100);
        check_output("lock_gnt2", 32'(gnt), 32'h4);
        check_output("lock_rdata1", 32'(rdata), 32'h55);
        set_field(0, 4'd10, 8'h00);
        apply_stimulus(4'b1111, 4'b0000, 4'b0100);
        check_output("lock_gnt3", 32'(gnt), 32'h4);
        apply_stimulus(4'b1011, 4'b0000, 4'b0000);
        check_output("unlock_gnt", 32'(gnt), 32'h8);
        apply_stimulus(4'b1011, 4'b0000, 4'b0000);
        check_output("after_unlock_gnt", 32'(gnt), 32'h1);
        check_output("after_unlock_rdata", 32'(rdata), 32'h88);
        apply_stimulus(4'b0000, 4'b0000, 4'b0000);

        $display("[TB] reset while a read result is pending");
        set_field(0, 4'd3, 8'h00);
        apply_stimulus(4'b0001, 4'b0000, 4'b0000);
        check_output("pre_reset_gnt", 32'(gnt), 32'h1);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        req     = 4'b0000;
        @(negedge clock);
        check_output("midreset_rvalid", 32'(rvalid), 0);
        check_output("midreset_rdata", 32'(rdata), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);

        $display("[TB] counter loop on address 0");
        set_field(0, 4'd0, 8'h00);
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(4'b0001, 4'b0000, 4'b0000);
            @(posedge clock);
            #1;
            check_output("cnt_rdata", 32'(rdata), 32'(k));
            check_output("cnt_rvalid", 32'(rvalid), 32'h1);
            we         = 4'b0001;
            wdata[7:0] = rdata + 8'd1;
            @(negedge clock);
        end
        apply_stimulus(4'b0000, 4'b0000, 4'b0000);

        $display("[TB] three-requester wrap");
        @(posedge clock);
        #1;
        req3 = 3'b101;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_output("wrap3_gnt", 32'(gnt3), 32'(g3_exp[k]));
            if (k < 3) begin
                @(posedge clock);
                #1;
            end
        end
        @(posedge clock);
        #1;
        req3 = 3'b000;
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
